// File: rtl/cafe_pkg.sv
// Shared definitions for the coffee-maker payment path: controller states,
// default money/type widths and the default drink price table.
package cafe_pkg;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        VEND     = 2'd1,
        DISPENSE = 2'd2
    } cafe_state_e;

    localparam int DEF_MONEY_W    = 4;
    localparam int DEF_TYPE_W     = 3;
    localparam int DEF_NTYPES     = 4;
    localparam int DEF_MAX_CREDIT = 15;

    // Slice i-1 holds the price of drink code i; the LSB slice is code 1.
    localparam logic [DEF_NTYPES*DEF_MONEY_W-1:0] DEF_PRICES = {4'd7, 4'd5, 4'd4, 4'd3};

endpackage

// File: rtl/tabla_precios.sv
// Combinational drink-code to price lookup over a packed price table.
// Codes 1..NTYPES are valid; any other code returns price 0 with valid low.
module tabla_precios
    import cafe_pkg::*;
#(
    parameter int                          MONEY_W = DEF_MONEY_W,
    parameter int                          TYPE_W  = DEF_TYPE_W,
    parameter int                          NTYPES  = DEF_NTYPES,
    parameter logic [NTYPES*MONEY_W-1:0]   PRICES  = DEF_PRICES
) (
    input  logic [TYPE_W-1:0]  c_type,
    output logic [MONEY_W-1:0] price,
    output logic               valid
);

    always_comb begin
        price = '0;
        valid = 1'b0;
        for (int i = 1; i <= NTYPES; i++) begin
            if (int'(c_type) == i) begin
                price = PRICES[(i-1)*MONEY_W +: MONEY_W];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cobrador_cafe.sv
// Payment controller: accumulates coin credit, approves drink selections
// against the price table and pays out change one unit per handshake.
module cobrador_cafe
    import cafe_pkg::*;
#(
    parameter int                          MONEY_W    = DEF_MONEY_W,
    parameter int                          TYPE_W     = DEF_TYPE_W,
    parameter int                          NTYPES     = DEF_NTYPES,
    parameter logic [NTYPES*MONEY_W-1:0]   PRICES     = DEF_PRICES,
    parameter int                          MAX_CREDIT = DEF_MAX_CREDIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coin_valid,
    input  logic [MONEY_W-1:0] coin_value,
    output logic               coin_ready,
    output logic               coin_reject,
    input  logic               sel_valid,
    input  logic [TYPE_W-1:0]  c_type,
    input  logic               cancel,
    output logic               ok,
    output logic               sel_err,
    output logic [MONEY_W-1:0] credit,
    output logic [MONEY_W-1:0] cambio,
    output logic               change_valid,
    input  logic               change_ack
);

    localparam logic [MONEY_W:0] MAX_SUM = (MONEY_W+1)'(MAX_CREDIT);

    cafe_state_e        state_q, state_d;
    logic [MONEY_W-1:0] credit_q, credit_d;
    logic [MONEY_W-1:0] cambio_q, cambio_d;
    logic               ok_q, ok_d;
    logic               sel_err_q, sel_err_d;
    logic               coin_reject_q, coin_reject_d;

    logic [MONEY_W-1:0] price;
    logic               price_ok;
    logic [MONEY_W:0]   coin_sum;

    tabla_precios #(
        .MONEY_W (MONEY_W),
        .TYPE_W  (TYPE_W),
        .NTYPES  (NTYPES),
        .PRICES  (PRICES)
    ) u_tabla (
        .c_type (c_type),
        .price  (price),
        .valid  (price_ok)
    );

    // One extra bit so an over-limit coin is seen as overflow, not a wrap.
    assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value};

    assign coin_ready   = (state_q == COLLECT) && !sel_valid && !cancel;
    assign change_valid = (state_q == DISPENSE) && (cambio_q != '0);
    assign credit       = credit_q;
    assign cambio       = cambio_q;
    assign ok           = ok_q;
    assign sel_err      = sel_err_q;
    assign coin_reject  = coin_reject_q;

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        cambio_d      = cambio_q;
        ok_d          = 1'b0;
        sel_err_d     = 1'b0;
        coin_reject_d = 1'b0;

        unique case (state_q)
            COLLECT: begin
                if (cancel) begin
                    if (credit_q != '0) begin
                        cambio_d = credit_q;
                        credit_d = '0;
                        state_d  = DISPENSE;
                    end
                end else if (sel_valid) begin
                    if (!price_ok || (credit_q < price)) begin
                        sel_err_d = 1'b1;
                    end else begin
                        cambio_d = credit_q - price;
                        credit_d = '0;
                        ok_d     = 1'b1;
                        state_d  = VEND;
                    end
                end else if (coin_valid && coin_ready) begin
                    if ((coin_value == '0) || (coin_sum > MAX_SUM)) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_d = coin_sum[MONEY_W-1:0];
                    end
                end
            end

            VEND: begin
                state_d = (cambio_q != '0) ? DISPENSE : COLLECT;
            end

            DISPENSE: begin
                if (change_ack && change_valid) begin
                    cambio_d = cambio_q - MONEY_W'(1);
                    if (cambio_q == MONEY_W'(1)) begin
                        state_d = COLLECT;
                    end
                end
            end

            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= COLLECT;
            credit_q      <= '0;
            cambio_q      <= '0;
            ok_q          <= 1'b0;
            sel_err_q     <= 1'b0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            cambio_q      <= cambio_d;
            ok_q          <= ok_d;
            sel_err_q     <= sel_err_d;
            coin_reject_q <= coin_reject_d;
        end
    end

endmodule

// File: tb/tb_cobrador_cafe.sv
// Self-checking bench for cobrador_cafe: directed scenarios plus random traffic
// against a transaction-level model, on the default and an 8-bit configuration.
module tb_cobrador_cafe;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Default configuration instance
    logic       a_coin_valid, a_sel_valid, a_cancel, a_change_ack;
    logic [3:0] a_coin_value;
    logic [2:0] a_c_type;
    logic       a_coin_ready, a_coin_reject, a_ok, a_sel_err, a_change_valid;
    logic [3:0] a_credit, a_cambio;

    // Wide-money configuration instance
    logic       b_coin_valid, b_sel_valid, b_cancel, b_change_ack;
    logic [7:0] b_coin_value;
    logic [2:0] b_c_type;
    logic       b_coin_ready, b_coin_reject, b_ok, b_sel_err, b_change_valid;
    logic [7:0] b_credit, b_cambio;

    cobrador_cafe dut_a (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (a_coin_valid),
        .coin_value   (a_coin_value),
        .coin_ready   (a_coin_ready),
        .coin_reject  (a_coin_reject),
        .sel_valid    (a_sel_valid),
        .c_type       (a_c_type),
        .cancel       (a_cancel),
        .ok           (a_ok),
        .sel_err      (a_sel_err),
        .credit       (a_credit),
        .cambio       (a_cambio),
        .change_valid (a_change_valid),
        .change_ack   (a_change_ack)
    );

    cobrador_cafe #(
        .MONEY_W    (8),
        .NTYPES     (2),
        .PRICES     ({8'd120, 8'd90}),
        .MAX_CREDIT (200)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (b_coin_valid),
        .coin_value   (b_coin_value),
        .coin_ready   (b_coin_ready),
        .coin_reject  (b_coin_reject),
        .sel_valid    (b_sel_valid),
        .c_type       (b_c_type),
        .cancel       (b_cancel),
        .ok           (b_ok),
        .sel_err      (b_sel_err),
        .credit       (b_credit),
        .cambio       (b_cambio),
        .change_valid (b_change_valid),
        .change_ack   (b_change_ack)
    );

    int which = 0;
    int total = 0;
    int bad   = 0;
    int step_no = 0;

    logic       o_coin_ready, o_coin_reject, o_ok, o_sel_err, o_change_valid;
    logic [7:0] o_credit, o_cambio;

    assign o_coin_ready   = (which == 0) ? a_coin_ready   : b_coin_ready;
    assign o_coin_reject  = (which == 0) ? a_coin_reject  : b_coin_reject;
    assign o_ok           = (which == 0) ? a_ok           : b_ok;
    assign o_sel_err      = (which == 0) ? a_sel_err      : b_sel_err;
    assign o_change_valid = (which == 0) ? a_change_valid : b_change_valid;
    assign o_credit       = (which == 0) ? {4'h0, a_credit} : b_credit;
    assign o_cambio       = (which == 0) ? {4'h0, a_cambio} : b_cambio;

    // Reference model: money as plain integers, a flag for the approval cycle
    // and a flag for an ongoing change payout.
    int m_credit, m_change, m_max, m_ntypes;
    int m_price[0:7];
    bit m_vend, m_paying;
    bit e_ok, e_sel_err, e_rej;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s step=%0d observed=%0d expected=%0d", tag, step_no, obs, exp);
        end
    endtask

    task automatic checkAll();
        checkOutput("ok",           32'(o_ok),           32'(e_ok));
        checkOutput("sel_err",      32'(o_sel_err),      32'(e_sel_err));
        checkOutput("coin_reject",  32'(o_coin_reject),  32'(e_rej));
        checkOutput("credit",       32'(o_credit),       32'(m_credit));
        checkOutput("cambio",       32'(o_cambio),       32'(m_change));
        checkOutput("change_valid", 32'(o_change_valid), 32'(m_paying && (m_change != 0)));
    endtask

    task automatic driveInputs(input bit cv, input int cval, input bit sv, input int ct,
                               input bit cn, input bit ack);
        if (which == 0) begin
            a_coin_valid = cv; a_coin_value = 4'(cval); a_sel_valid = sv;
            a_c_type = 3'(ct); a_cancel = cn; a_change_ack = ack;
        end else begin
            b_coin_valid = cv; b_coin_value = 8'(cval); b_sel_valid = sv;
            b_c_type = 3'(ct); b_cancel = cn; b_change_ack = ack;
        end
    endtask

    task automatic modelStep(input bit cv, input int cval, input bit sv, input int ct,
                             input bit cn, input bit ack);
        e_ok = 1'b0; e_sel_err = 1'b0; e_rej = 1'b0;
        if (m_vend) begin
            m_vend   = 1'b0;
            m_paying = (m_change != 0);
        end else if (m_paying) begin
            if (ack && m_change > 0) begin
                m_change--;
                if (m_change == 0) m_paying = 1'b0;
            end
        end else if (cn) begin
            if (m_credit > 0) begin
                m_change = m_credit;
                m_credit = 0;
                m_paying = 1'b1;
            end
        end else if (sv) begin
            if (ct < 1 || ct > m_ntypes) begin
                e_sel_err = 1'b1;
            end else if (m_credit < m_price[ct]) begin
                e_sel_err = 1'b1;
            end else begin
                m_change = m_credit - m_price[ct];
                m_credit = 0;
                m_vend   = 1'b1;
                e_ok     = 1'b1;
            end
        end else if (cv) begin
            if (cval == 0 || m_credit + cval > m_max) e_rej = 1'b1;
            else m_credit += cval;
        end
    endtask

    // One clock of stimulus: check the combinational ready, advance the model,
    // clock the DUT, then check every registered output.
    task automatic applyStimulus(input bit cv, input int cval, input bit sv, input int ct,
                                 input bit cn, input bit ack);
        step_no++;
        driveInputs(cv, cval, sv, ct, cn, ack);
        #1;
        checkOutput("coin_ready", 32'(o_coin_ready), 32'(!m_vend && !m_paying && !sv && !cn));
        modelStep(cv, cval, sv, ct, cn, ack);
        @(posedge clk);
        #1;
        driveInputs(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        checkAll();
    endtask

    task automatic idle(input bit ack);
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b0, ack);
    endtask

    task automatic modelReset();
        m_credit = 0; m_change = 0; m_vend = 1'b0; m_paying = 1'b0;
        e_ok = 1'b0; e_sel_err = 1'b0; e_rej = 1'b0;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        driveInputs(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        checkAll();
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Pays out pending change with a given ack pattern; bounded by a cycle budget.
    task automatic drainChange(input int mode);
        for (int n = 0; n < 80 && (m_paying || m_vend); n++) begin
            case (mode)
                0:       idle(1'b1);
                1:       idle(n % 3 != 0);
                default: idle(1'($urandom_range(0, 1)));
            endcase
        end
    endtask

    initial begin
        rst = 1'b1;
        which = 0;
        driveInputs(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        which = 1;
        driveInputs(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        which = 0;
        m_max = 15; m_ntypes = 4;
        m_price = '{0, 3, 4, 5, 7, 0, 0, 0};

        $display("[TB] default configuration");
        resetDut();

        // Coins 2,2 then drink 1 (price 3): one unit of change
        applyStimulus(1'b1, 2, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2, 1'b0, 0, 1'b0, 1'b0);
        checkOutput("credit_after_two_coins", 32'(a_credit), 32'd4);
        applyStimulus(1'b0, 0, 1'b1, 1, 1'b0, 1'b0);
        checkOutput("ok_after_sel", 32'(a_ok), 32'd1);
        checkOutput("cambio_after_sel", 32'(a_cambio), 32'd1);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Insufficient credit, then exact payment skips the payout
        applyStimulus(1'b1, 5, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 4, 1'b0, 1'b0);
        applyStimulus(1'b1, 2, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 4, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("no_payout_exact", 32'(a_change_valid), 32'd0);
        idle(1'b0);

        // Overflow rejection, fill to the limit, cancel and pay out 15 with gaps
        applyStimulus(1'b1, 7, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 7, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        checkOutput("cambio_after_cancel", 32'(a_cambio), 32'd15);
        drainChange(1);
        idle(1'b1);

        // Invalid codes and a coin colliding with a selection
        applyStimulus(1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 5, 1'b0, 1'b0);
        applyStimulus(1'b1, 2, 1'b1, 4, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        drainChange(0);

        // Asynchronous reset in the middle of a 3-unit payout
        applyStimulus(1'b1, 7, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 2, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("dispense_pending", 32'(a_cambio), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle(1'b1);
        applyStimulus(1'b1, 3, 1'b0, 0, 1'b0, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 9) < 4, int'($urandom_range(0, 6)),
                          $urandom_range(0, 19) < 3, int'($urandom_range(0, 5)),
                          $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)));
        end
        drainChange(2);

        $display("[TB] 8-bit configuration");
        which = 1;
        m_max = 200; m_ntypes = 2;
        m_price = '{0, 90, 120, 0, 0, 0, 0, 0};
        resetDut();
        applyStimulus(1'b1, 100, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 50, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 2, 1'b0, 1'b0);
        checkOutput("wide_cambio", 32'(b_cambio), 32'd30);
        drainChange(0);
        applyStimulus(1'b1, 150, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 60, 1'b0, 0, 1'b0, 1'b0);
        checkOutput("wide_reject", 32'(b_coin_reject), 32'd1);
        applyStimulus(1'b0, 0, 1'b1, 3, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) begin
            applyStimulus($urandom_range(0, 9) < 4, int'($urandom_range(0, 120)),
                          $urandom_range(0, 9) < 2, int'($urandom_range(0, 3)),
                          $urandom_range(0, 19) == 0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
